// File: rtl/radix_divider.sv
// radix_divider: iterative restoring integer divider that retires
// BITS_PER_CYCLE quotient bits per clock, with signed or unsigned operands
// selected per operation.
//
// Latency is WIDTH/BITS_PER_CYCLE + 1 clocks from the start edge to the
// done pulse.
//
// Divide-by-zero returns quotient all ones, remainder = dividend and sets
// fault. The signed most-negative / -1 case wraps to quotient = dividend.
//
// Optional feature: define RADIX_DIVIDER_EARLY_EXIT_EN to let trivial
// operations complete in the start cycle without raising busy. These are:
// zero divisor, zero dividend, divisor 1, signed divisor -1, and
// |divisor| > |dividend|.
module radix_divider #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             fault,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(N - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FINISH
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] dvd_raw_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             zero_div_q;

  logic             in_neg_dvd;
  logic             in_neg_dvs;
  logic [WIDTH-1:0] in_dvd_mag;
  logic [WIDTH-1:0] in_dvs_mag;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  logic             early_hit;
  logic [WIDTH-1:0] early_quo;
  logic [WIDTH-1:0] early_rem;
  logic             early_fault;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  // Operand signs and magnitudes. Negating the most negative value yields
  // the same bit pattern, which is its correct unsigned magnitude.
  always_comb begin
    in_neg_dvd = signed_mode & dividend[WIDTH-1];
    in_neg_dvs = signed_mode & divisor[WIDTH-1];
    in_dvd_mag = in_neg_dvd ? negate(dividend) : dividend;
    in_dvs_mag = in_neg_dvs ? negate(divisor) : divisor;
  end

  // Chain of restoring steps for one clock. The quotient register starts
  // out holding the dividend magnitude; its top bit is shifted into the
  // partial remainder, and each new quotient bit enters at the bottom.
  // The extra remainder bit acts as the borrow of the trial subtraction.
  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    shifted  = '0;
    diff     = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted  = {step_rem[WIDTH-1:0], step_quo[WIDTH-1]};
      diff     = shifted - {1'b0, dvs_q};
      step_quo = {step_quo[WIDTH-2:0], ~diff[WIDTH]};
      step_rem = diff[WIDTH] ? shifted : diff;
    end
  end

`ifdef RADIX_DIVIDER_EARLY_EXIT_EN
  // Detect operations whose result is known without iterating. The
  // results match what the iterative path would produce.
  always_comb begin
    early_hit   = 1'b0;
    early_quo   = '0;
    early_rem   = '0;
    early_fault = 1'b0;
    if (divisor == '0) begin
      early_hit   = 1'b1;
      early_quo   = '1;
      early_rem   = dividend;
      early_fault = 1'b1;
    end else if (dividend == '0) begin
      early_hit = 1'b1;
    end else if (divisor == ONE) begin
      early_hit = 1'b1;
      early_quo = dividend;
    end else if (signed_mode && (divisor == '1)) begin
      early_hit = 1'b1;
      early_quo = negate(dividend);
    end else if (in_dvs_mag > in_dvd_mag) begin
      early_hit = 1'b1;
      early_rem = dividend;
    end
  end
`else
  // Without early exit every operation takes the iterative path.
  always_comb begin
    early_hit   = 1'b0;
    early_quo   = '0;
    early_rem   = '0;
    early_fault = 1'b0;
  end
`endif

  // Control FSM and datapath registers: accept, iterate N times, then
  // sign-correct and publish the results with a one-cycle done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dvd_raw_q  <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      fault      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && early_hit) begin
            quotient  <= early_quo;
            remainder <= early_rem;
            fault     <= early_fault;
            done      <= 1'b1;
          end else if (start) begin
            rem_q      <= '0;
            quo_q      <= in_dvd_mag;
            dvs_q      <= in_dvs_mag;
            dvd_raw_q  <= dividend;
            neg_quo_q  <= in_neg_dvd ^ in_neg_dvs;
            neg_rem_q  <= in_neg_dvd;
            zero_div_q <= (divisor == '0);
            count      <= '0;
            busy       <= 1'b1;
            state      <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          count <= count + CNT_ONE;
          if (count == LAST) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          if (zero_div_q) begin
            quotient  <= '1;
            remainder <= dvd_raw_q;
            fault     <= 1'b1;
          end else begin
            quotient  <= neg_quo_q ? negate(quo_q) : quo_q;
            remainder <= neg_rem_q ? negate(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
            fault     <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
